// File: rtl/data_memory_unit.sv
// data_memory_unit: byte-addressed little-endian data memory with a single
// registered response stage (1-cycle latency, no stalls).
// Optional feature macro: DMEM_SIGN_EXT_EN
//   defined   -> byte/half loads sign-extend unless unsigned_ld=1
//   undefined -> byte/half loads always zero-extend, unsigned_ld ignored
// Memory contents are never reset; only the response register is.
module data_memory_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  resp_valid,
  output logic                  err
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Parameter legality is checked at elaboration.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("data_memory_unit: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 4 || ADDR_WIDTH > 16) begin : g_bad_addr_width
    $error("data_memory_unit: ADDR_WIDTH must be in 4..16");
  end

  // Byte storage.
  logic [7:0] r_mem [DEPTH];

  // Response register: pending flag, error flag, load result.
  logic                  r_resp_vld;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Request decode.
  logic                  w_any;
  logic                  w_both;
  logic                  w_misalign;
  logic                  w_reject;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_sext;
  logic [NUM_LANES-1:0]  w_be;
  logic [DATA_WIDTH-1:0] w_load;

  // Per-lane byte address and data.
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] w_lane_addr;
  logic [NUM_LANES-1:0][7:0]            w_rd_bytes;
  logic [NUM_LANES-1:0][7:0]            w_wr_bytes;

  assign w_any  = mem_read | mem_write;
  assign w_both = mem_read & mem_write;

  // Halfwords need addr[0]=0, words need addr[1:0]=00.
  assign w_misalign = ((size == SZ_HALF) && address[0]) ||
                      ((size == SZ_WORD) && (address[1:0] != 2'b00));

  // Reserved size, misalignment and read+write together are all rejected.
  assign w_reject = w_both || (size == 2'b11) || w_misalign;

  assign w_wr_ok = mem_write & ~mem_read & ~w_reject;
  assign w_rd_ok = mem_read & ~mem_write & ~w_reject;

`ifdef DMEM_SIGN_EXT_EN
  assign w_sext = ~unsigned_ld;
`else
  // Extension is fixed to zero-fill; unsigned_ld is read only to keep the
  // port connected to logic.
  assign w_sext = 1'b0 & unsigned_ld;
`endif

  // Lanes enabled by the access size. Aligned accesses never run past the
  // top of memory, so lane addresses of enabled lanes never wrap.
  always_comb begin
    w_be = '0;
    case (size)
      SZ_BYTE: w_be = 4'b0001;
      SZ_HALF: w_be = 4'b0011;
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_lane_addr[g] = address + ADDR_WIDTH'(g);
    assign w_rd_bytes[g]  = r_mem[w_lane_addr[g]];
    assign w_wr_bytes[g]  = write_data[8*g +: 8];
  end

  // Assemble the load result with the requested extension.
  always_comb begin
    w_load = '0;
    case (size)
      SZ_BYTE: w_load = {{24{w_sext & w_rd_bytes[0][7]}}, w_rd_bytes[0]};
      SZ_HALF: w_load = {{16{w_sext & w_rd_bytes[1][7]}},
                         w_rd_bytes[1], w_rd_bytes[0]};
      default: w_load = {w_rd_bytes[3], w_rd_bytes[2],
                         w_rd_bytes[1], w_rd_bytes[0]};
    endcase
  end

  // Store commit: only the enabled byte lanes of an accepted store.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_wr_ok && w_be[i]) r_mem[w_lane_addr[i]] <= w_wr_bytes[i];
    end
  end

  // Response register: one pulse per request; read data only moves on a
  // successful load, so stores and errors leave it holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_vld <= 1'b0;
      r_resp_err <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_resp_vld <= w_any;
      r_resp_err <= w_any & w_reject;
      if (w_rd_ok) r_rdata <= w_load;
    end
  end

  assign read_data  = r_rdata;
  assign resp_valid = r_resp_vld;
  assign err        = r_resp_err;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit (ADDR_WIDTH=8). Inputs change on the
// falling edge, outputs are sampled 1ns after the rising edge.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        resp_valid;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

`ifdef DMEM_SIGN_EXT_EN
  localparam logic [31:0] EXP_B85_SGN  = 32'hFFFF_FF85;
  localparam logic [31:0] EXP_H8001_SGN = 32'hFFFF_8001;
`else
  localparam logic [31:0] EXP_B85_SGN  = 32'h0000_0085;
  localparam logic [31:0] EXP_H8001_SGN = 32'h0000_8001;
`endif

  data_memory_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .resp_valid (resp_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request cycle and return 1ns after the sampling edge + 1,
  // i.e. when the response of this request is visible.
  task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [7:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    unsigned_ld = uns;
    address     = a;
    write_data  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic e, input logic [31:0] rd);
    chk({tag, ".vld"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, e});
    chk({tag, ".data"}, read_data, rd);
  endtask

  initial begin
    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.data", read_data, 32'h0);
    chk("rst.vld", {31'b0, resp_valid}, 32'd0);
    chk("rst.err", {31'b0, err}, 32'd0);

    // Store sampled in the release cycle is processed.
    @(negedge clk);
    rst_n       = 1'b1;
    mem_write   = 1'b1;
    size        = 2'b10;
    address     = 8'h00;
    write_data  = 32'h1000_0002;
    @(posedge clk);
    #1;
    chk_resp("st_w0", 1'b0, 32'h0);

    req(1, 0, 2'b10, 0, 8'h00, 32'h0);
    chk_resp("ld_w0", 1'b0, 32'h1000_0002);

    // Byte store then immediate load of the containing word.
    req(0, 1, 2'b00, 0, 8'h01, 32'hFFFF_FF77);
    chk_resp("st_b1", 1'b0, 32'h1000_0002);
    req(1, 0, 2'b10, 0, 8'h00, 32'h0);
    chk_resp("ld_w0b", 1'b0, 32'h1000_7702);

    // Clear word 4 so later checks do not depend on power-up contents.
    req(0, 1, 2'b10, 0, 8'h04, 32'h0);
    req(0, 1, 2'b00, 0, 8'h04, 32'h0000_0085);
    req(1, 0, 2'b00, 0, 8'h04, 32'h0);
    chk_resp("ld_b4s", 1'b0, EXP_B85_SGN);
    req(1, 0, 2'b00, 1, 8'h04, 32'h0);
    chk_resp("ld_b4u", 1'b0, 32'h0000_0085);

    // Misaligned word store rejected, nothing written, data held.
    req(0, 1, 2'b10, 0, 8'h06, 32'hDEAD_BEEF);
    chk_resp("st_mis", 1'b1, 32'h0000_0085);
    req(1, 0, 2'b10, 0, 8'h04, 32'h0);
    chk_resp("ld_w4", 1'b0, 32'h0000_0085);

    // Read+write together, reserved size, misaligned half load.
    req(1, 1, 2'b10, 0, 8'h00, 32'h1234_5678);
    chk_resp("both", 1'b1, 32'h0000_0085);
    req(1, 0, 2'b11, 0, 8'h00, 32'h0);
    chk_resp("sz11", 1'b1, 32'h0000_0085);
    req(1, 0, 2'b01, 0, 8'h01, 32'h0);
    chk_resp("h_mis", 1'b1, 32'h0000_0085);
    req(1, 0, 2'b10, 0, 8'h00, 32'h0);
    chk_resp("ld_w0c", 1'b0, 32'h1000_7702);

    // Halfword store only touches its two bytes.
    req(0, 1, 2'b10, 0, 8'h08, 32'h1122_3344);
    req(0, 1, 2'b01, 0, 8'h08, 32'hABCD_8001);
    req(1, 0, 2'b10, 0, 8'h08, 32'h0);
    chk_resp("ld_w8", 1'b0, 32'h1122_8001);
    req(1, 0, 2'b01, 0, 8'h08, 32'h0);
    chk_resp("ld_h8s", 1'b0, EXP_H8001_SGN);
    req(1, 0, 2'b01, 1, 8'h0A, 32'h0);
    chk_resp("ld_hA", 1'b0, 32'h0000_1122);

    // Top-of-memory word and its last byte.
    req(0, 1, 2'b10, 0, 8'hFC, 32'hCAFE_F00D);
    chk_resp("st_top", 1'b0, 32'h0000_1122);
    req(1, 0, 2'b10, 0, 8'hFC, 32'h0);
    chk_resp("ld_top", 1'b0, 32'hCAFE_F00D);
    req(1, 0, 2'b00, 1, 8'hFF, 32'h0);
    chk_resp("ld_bFF", 1'b0, 32'h0000_00CA);

    // No request -> no response.
    idle();
    chk("idle.vld", {31'b0, resp_valid}, 32'd0);
    chk("idle.err", {31'b0, err}, 32'd0);

    // Reset mid-cycle with a load response pending.
    req(1, 0, 2'b10, 0, 8'h00, 32'h0);
    chk("pend.vld", {31'b0, resp_valid}, 32'd1);
    mem_read = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.data", read_data, 32'h0);
    chk("arst.vld", {31'b0, resp_valid}, 32'd0);
    chk("arst.err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req(1, 0, 2'b10, 0, 8'h00, 32'h0);
    chk_resp("post_rst", 1'b0, 32'h1000_7702);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
